// File: rtl/idct_mul_pkg.sv
// Shared constants and state encoding for the IDCT multiplier scheduler.
package idct_mul_pkg;

   localparam int DATA_PATH_BITWIDTH = 26;
   localparam int B_BITWIDTH         = 15;
   localparam int P_BITWIDTH         = 32;

   // Scheduler states; any other encoding is treated as IDLE.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3
   } state_t;

endpackage

// File: rtl/idct_mul_share_sched_rr_arb2.sv
// Two-way round-robin arbiter: the requester that did not win last time has
// priority. The last_grant register is kept by the parent.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   // Prefer the requester other than last_grant, fall back to the other one.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant_valid = |req;
      grant_id    = 1'b0;
      if (req[~last_grant]) begin
         grant_id = ~last_grant;
      end else if (req[last_grant]) begin
         grant_id = last_grant;
      end
   end

endmodule

// File: rtl/idct_mul_share_sched.sv
// Shares one external configurable multiplier between the IDCT row pass (req0)
// and column pass (req1): round-robin grant, operand issue, fixed-latency wait
// and a registered valid/ready response back to the granted requester.
module idct_mul_share_sched
   import idct_mul_pkg::*;
#(
   parameter int MUL_LAT = 1
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic [1:0]                    req_valid,
   output logic [1:0]                    req_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] req_a0,
   input  logic [DATA_PATH_BITWIDTH-1:0] req_a1,
   input  logic [B_BITWIDTH-1:0]         req_b0,
   input  logic [B_BITWIDTH-1:0]         req_b1,
   input  logic [1:0]                    req_apx,
   output logic [DATA_PATH_BITWIDTH-1:0] mul_a,
   output logic [B_BITWIDTH-1:0]         mul_b,
   output logic                          acc__sel,
   input  logic [P_BITWIDTH-1:0]         mul_p,
   output logic                          rsp_valid,
   output logic                          rsp_id,
   output logic [P_BITWIDTH-1:0]         rsp_p,
   input  logic                          rsp_ready,
   output logic                          busy,
   output logic [8:0]                    count0,
   output logic [2:0]                    state_out
);

   state_t                        state;
   state_t                        state_nxt;
   logic                          last_grant;
   logic                          grant_id;
   logic                          grant_valid;
   logic                          arb_id;
   logic [2:0]                    wait_cnt;
   logic [DATA_PATH_BITWIDTH-1:0] a_reg;
   logic [B_BITWIDTH-1:0]         b_reg;
   logic                          apx_reg;

   rr_arb2 u_arb (
      .req         (req_valid),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (arb_id)
   );

   // Operands are held in registers from acceptance until the next acceptance,
   // so the multiplier inputs never change while a product is in flight.
   assign mul_a     = a_reg;
   assign mul_b     = b_reg;
   assign acc__sel  = ~apx_reg;
   assign busy      = (state != IDLE);
   assign state_out = state;

   // Next-state and request-accept logic.
   always_comb begin
      state_nxt = IDLE;
      req_ready = 2'b00;
      case (state)
         IDLE: begin
            state_nxt = IDLE;
            if (grant_valid) begin
               req_ready = arb_id ? 2'b10 : 2'b01;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT:  state_nxt = (wait_cnt == 3'd0) ? RESP : WAIT;
         RESP:  state_nxt = rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   // State, operand, wait-counter, response and completion-counter registers.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         wait_cnt   <= 3'd0;
         a_reg      <= '0;
         b_reg      <= '0;
         apx_reg    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_p      <= '0;
         count0     <= 9'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  a_reg      <= arb_id ? req_a1 : req_a0;
                  b_reg      <= arb_id ? req_b1 : req_b0;
                  apx_reg    <= req_apx[arb_id];
                  grant_id   <= arb_id;
                  last_grant <= arb_id;
               end
            end
            ISSUE: wait_cnt <= 3'(MUL_LAT - 1);
            WAIT: begin
               if (wait_cnt == 3'd0) begin
                  rsp_p     <= mul_p;
                  rsp_valid <= 1'b1;
                  rsp_id    <= grant_id;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  count0    <= count0 + 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_idct_mul_share_sched.sv
// Self-checking bench for idct_mul_share_sched: a transaction-level model checks
// the MUL_LAT=1 instance every cycle; directed tests add hand-computed values.
// A second instance with MUL_LAT=3 covers the latency parameter.
module tb_idct_mul_share_sched;

   localparam int LAT1 = 1;

   logic        clk;
   logic        rstN;

   // MUL_LAT=1 instance
   logic [1:0]  req_valid, req_ready, req_apx;
   logic [25:0] req_a0, req_a1, mul_a;
   logic [14:0] req_b0, req_b1, mul_b;
   logic        acc_sel, rsp_valid, rsp_id, rsp_ready, busy;
   logic [31:0] mul_p, rsp_p;
   logic [8:0]  count0;
   logic [2:0]  state_out;

   // MUL_LAT=3 instance
   logic [1:0]  req_valid_3, req_ready_3, req_apx_3;
   logic [25:0] req_a0_3, req_a1_3, mul_a_3;
   logic [14:0] req_b0_3, req_b1_3, mul_b_3;
   logic        acc_sel_3, rsp_valid_3, rsp_id_3, rsp_ready_3, busy_3;
   logic [31:0] mul_p_3, rsp_p_3;
   logic [8:0]  count0_3;
   logic [2:0]  state_out_3;
   logic [31:0] p_pipe [3];

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] prod32(input logic [25:0] a, input logic [14:0] b);
      logic [40:0] full;
      full = {15'b0, a} * {26'b0, b};
      return full[31:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   idct_mul_share_sched #(.MUL_LAT(1)) dut (
      .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
      .req_apx(req_apx), .mul_a(mul_a), .mul_b(mul_b), .acc__sel(acc_sel),
      .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
      .rsp_ready(rsp_ready), .busy(busy), .count0(count0), .state_out(state_out)
   );

   idct_mul_share_sched #(.MUL_LAT(3)) dut3 (
      .clk(clk), .rstN(rstN), .req_valid(req_valid_3), .req_ready(req_ready_3),
      .req_a0(req_a0_3), .req_a1(req_a1_3), .req_b0(req_b0_3), .req_b1(req_b1_3),
      .req_apx(req_apx_3), .mul_a(mul_a_3), .mul_b(mul_b_3), .acc__sel(acc_sel_3),
      .mul_p(mul_p_3), .rsp_valid(rsp_valid_3), .rsp_id(rsp_id_3), .rsp_p(rsp_p_3),
      .rsp_ready(rsp_ready_3), .busy(busy_3), .count0(count0_3), .state_out(state_out_3)
   );

   // Zero-latency multiplier for the first instance.
   assign mul_p = prod32(mul_a, mul_b);

   // Three-stage multiplier for the second instance.
   always @(posedge clk) begin
      p_pipe[0] <= prod32(mul_a_3, mul_b_3);
      p_pipe[1] <= p_pipe[0];
      p_pipe[2] <= p_pipe[1];
   end
   assign mul_p_3 = p_pipe[2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- transaction model of the MUL_LAT=1 instance ----------------
   logic        m_live = 1'b0;
   logic        m_out, m_last, m_acc, m_id;
   logic [8:0]  m_count;
   logic [25:0] m_a;
   logic [14:0] m_b;
   int          m_cyc = 0;
   int          m_t0;

   always @(negedge clk) begin
      logic [1:0] exp_ready;
      logic       g;
      logic       exp_rv;
      logic [2:0] exp_state;
      m_cyc     = m_cyc + 1;
      exp_ready = 2'b00;
      g         = 1'b0;
      exp_rv    = 1'b0;
      if (m_live) begin
         if (!m_out && req_valid != 2'b00) begin
            g = req_valid[~m_last] ? ~m_last : m_last;
            exp_ready[g] = 1'b1;
         end
         exp_rv = m_out && (m_cyc >= m_t0 + LAT1 + 2);
         if (!m_out)                 exp_state = 3'd0;
         else if (m_cyc == m_t0 + 1) exp_state = 3'd1;
         else if (!exp_rv)           exp_state = 3'd2;
         else                        exp_state = 3'd3;
         check("mon_req_ready", 32'(req_ready), 32'(exp_ready));
         check("mon_busy", 32'(busy), 32'(m_out));
         check("mon_state", 32'(state_out), 32'(exp_state));
         check("mon_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         check("mon_count0", 32'(count0), 32'(m_count));
         check("mon_acc_sel", 32'(acc_sel), 32'(m_acc));
         check("mon_mul_a", 32'(mul_a), 32'(m_a));
         check("mon_mul_b", 32'(mul_b), 32'(m_b));
         if (exp_rv) begin
            check("mon_rsp_id", 32'(rsp_id), 32'(m_id));
            check("mon_rsp_p", rsp_p, prod32(m_a, m_b));
         end
      end
      // Advance the model across the coming edge.
      if (!rstN) begin
         m_live  = 1'b1;
         m_out   = 1'b0;
         m_last  = 1'b1;
         m_acc   = 1'b1;
         m_id    = 1'b0;
         m_count = 9'd0;
         m_a     = '0;
         m_b     = '0;
      end else if (m_live) begin
         if (exp_ready != 2'b00) begin
            m_out  = 1'b1;
            m_t0   = m_cyc;
            m_id   = g;
            m_last = g;
            m_a    = g ? req_a1 : req_a0;
            m_b    = g ? req_b1 : req_b0;
            m_acc  = ~req_apx[g];
         end else if (exp_rv && rsp_ready) begin
            m_out   = 1'b0;
            m_count = m_count + 9'd1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
   endtask

   task automatic wait_ready();
      int c;
      c = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("wait_ready_bound", 32'(req_ready != 2'b00), 32'd1);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      @(negedge clk);
      while (busy && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("wait_idle_bound", 32'(busy), 32'd0);
   endtask

   initial begin
      int n, c, nw;
      rstN = 1'b0;
      req_valid = '0; req_apx = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
      rsp_ready = 1'b1;
      req_valid_3 = '0; req_apx_3 = '0; req_a0_3 = '0; req_a1_3 = '0; req_b0_3 = '0; req_b1_3 = '0;
      rsp_ready_3 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;

      // Reset state.
      @(negedge clk);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_p", rsp_p, 32'd0);
      check("rst_count0", 32'(count0), 32'd0);
      check("rst_acc_sel", 32'(acc_sel), 32'd1);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst3_state", 32'(state_out_3), 32'd0);

      // Single request from the row pass.
      tick();
      req_valid = 2'b01; req_a0 = 26'h0001234; req_b0 = 15'h0056; req_apx = 2'b00;
      @(negedge clk);
      check("t1_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("t1_issue_state", 32'(state_out), 32'd1);
      check("t1_issue_acc", 32'(acc_sel), 32'd1);
      tick();
      @(negedge clk);
      check("t1_wait_state", 32'(state_out), 32'd2);
      check("t1_wait_acc", 32'(acc_sel), 32'd1);
      check("t1_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t1_rsp_id", 32'(rsp_id), 32'd0);
      check("t1_rsp_p", rsp_p, 32'h0006_1D78);
      tick();
      @(negedge clk);
      check("t1_count0", 32'(count0), 32'd1);
      check("t1_idle", 32'(state_out), 32'd0);

      // Contention: both requesters held valid for four operations.
      do_reset();
      req_valid = 2'b11; req_a0 = 26'd3; req_b0 = 15'd5; req_a1 = 26'd7; req_b1 = 15'd11;
      n = 0; c = 0;
      while (n < 4 && c < 200) begin
         @(negedge clk);
         c++;
         if (req_ready != 2'b00) begin
            check("t2_onehot", 32'($countones(req_ready)), 32'd1);
            check("t2_grant", 32'(req_ready), n[0] ? 32'd2 : 32'd1);
            n++;
            if (n == 4) begin
               tick();
               req_valid = 2'b00;
            end
         end
      end
      check("t2_ops", 32'(n), 32'd4);
      wait_idle();
      check("t2_count0", 32'(count0), 32'd4);

      // Mode switch: row pass approximate, column pass accurate.
      tick();
      req_valid = 2'b11; req_apx = 2'b01;
      req_a0 = 26'h2AAAAAA; req_b0 = 15'h1555; req_a1 = 26'h1555555; req_b1 = 15'h2AAA;
      for (int k = 0; k < 2; k++) begin
         wait_ready();
         check("t3_grant", 32'(req_ready), (k == 0) ? 32'd1 : 32'd2);
         tick();
         if (k == 1) req_valid = 2'b00;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_acc_sel", 32'(acc_sel), (k == 0) ? 32'd0 : 32'd1);
            check("t3_mul_a", 32'(mul_a), (k == 0) ? 32'h2AAAAAA : 32'h1555555);
            check("t3_mul_b", 32'(mul_b), (k == 0) ? 32'h1555 : 32'h2AAA);
            tick();
         end
      end
      req_apx = 2'b00;

      // Backpressure with a new request pending from the column pass.
      tick();
      rsp_ready = 1'b0; req_valid = 2'b01;
      req_a0 = 26'h3FFFFFF; req_b0 = 15'h7FFF; req_a1 = 26'h0000010; req_b1 = 15'h0020;
      wait_ready();
      check("t4_grant", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b10;
      c = 0;
      @(negedge clk);
      while (!rsp_valid && c < 20) begin
         @(negedge clk);
         c++;
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            tick();
            @(negedge clk);
         end
         check("t4_hold_valid", 32'(rsp_valid), 32'd1);
         check("t4_hold_id", 32'(rsp_id), 32'd0);
         check("t4_hold_p", rsp_p, 32'hFBFF_8001);
         check("t4_hold_ready", 32'(req_ready), 32'd0);
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_resp_ready", 32'(req_ready), 32'd0);
      tick();
      @(negedge clk);
      check("t4_new_accept", 32'(req_ready), 32'd2);
      tick();
      req_valid = 2'b00;
      wait_idle();
      check("t4_count0", 32'(count0), 32'd8);

      // Reset in the middle of WAIT.
      tick();
      req_valid = 2'b01; req_apx = 2'b01; req_a0 = 26'h0000ABC; req_b0 = 15'h0003;
      wait_ready();
      tick();
      req_valid = 2'b00; req_apx = 2'b00;
      @(negedge clk);
      check("t5_acc_apx", 32'(acc_sel), 32'd0);
      tick();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      @(negedge clk);
      check("t5_state", 32'(state_out), 32'd0);
      check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_count0", 32'(count0), 32'd0);
      check("t5_acc_sel", 32'(acc_sel), 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         check("t5_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Completion counter wrap: 511 operations then one more.
      tick();
      req_valid = 2'b01; req_a0 = 26'd2; req_b0 = 15'd3;
      c = 0;
      @(negedge clk);
      while (count0 != 9'd511 && c < 3000) begin
         @(negedge clk);
         c++;
      end
      check("t6_reach_511", 32'(count0), 32'd511);
      tick();
      req_valid = 2'b00;
      c = 0;
      @(negedge clk);
      while (count0 == 9'd511 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("t6_wrap", 32'(count0), 32'd0);
      tick();
      @(negedge clk);
      check("t6_idle", 32'(busy), 32'd0);

      // MUL_LAT=3 instance: latency and capture point.
      tick();
      req_valid_3 = 2'b01; req_a0_3 = 26'h0001234; req_b0_3 = 15'h0056;
      c = 0;
      @(negedge clk);
      while (req_ready_3 == 2'b00 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("t7_grant", 32'(req_ready_3), 32'd1);
      tick();
      req_valid_3 = 2'b00;
      n = 0; nw = 0;
      @(negedge clk);
      while (!rsp_valid_3 && n < 20) begin
         if (state_out_3 == 3'd2) nw++;
         n++;
         @(negedge clk);
      end
      check("t7_latency", 32'(n), 32'd4);
      check("t7_wait_cycles", 32'(nw), 32'd3);
      check("t7_rsp_p", rsp_p_3, 32'h0006_1D78);
      check("t7_rsp_id", 32'(rsp_id_3), 32'd0);
      tick();
      @(negedge clk);
      check("t7_count0", 32'(count0_3), 32'd1);
      check("t7_idle", 32'(busy_3), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
